// File: rtl/count_capture_pkg.sv
// Shared defaults and width helpers for the count capture unit.
package count_capture_pkg;

    localparam int CNT_W_DEFAULT = 4;
    localparam int DEPTH_DEFAULT = 4;

    // Pointer width for a power-of-two depth; level needs one extra bit to hold DEPTH itself.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int PTR_W_DEFAULT = ptr_width(DEPTH_DEFAULT);
    localparam int LVL_W_DEFAULT = lvl_width(DEPTH_DEFAULT);

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with an explicit occupancy counter.
// A push while full is accepted only when a pop happens on the same edge.
module sync_fifo
    import count_capture_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int PTR_W = ptr_width(DEPTH),
    localparam int LVL_W = lvl_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // Pop needs data present; push needs room, which a same-edge pop provides.
    always_comb begin
        rd_ok = pop & ~empty;
        wr_ok = push & (~full | rd_ok);
    end

    // Storage is deliberately left without reset; out_data is ignored while empty.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at power-of-two depth; level tracks occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/count_capture_unit.sv
// Captures the upstream count on each rising edge of an asynchronous event into
// a small FIFO, flags dropped captures, and pulses when the count wraps.
module count_capture_unit
    import count_capture_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CNT_W-1:0]         cnt_in,
    input  logic                     evt_in,
    output logic [CNT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output logic                     wrap_pulse
);

    logic             evt_s1;
    logic             evt_s2;
    logic             evt_s3;
    logic             cap_req_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             drop;

    // Two-flop synchronizer, edge-detect flop, and a registered request so the
    // write lands three edges after the event is first sampled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_s1    <= 1'b0;
            evt_s2    <= 1'b0;
            evt_s3    <= 1'b0;
            cap_req_q <= 1'b0;
        end else begin
            evt_s1    <= evt_in;
            evt_s2    <= evt_s1;
            evt_s3    <= evt_s2;
            cap_req_q <= evt_s2 & ~evt_s3;
        end
    end

    // Push/pop qualification and drop detection.
    always_comb begin
        push = cap_req_q;
        pop  = out_valid & out_ready;
        drop = push & full & ~pop;
    end

    // Sticky overflow; a drop on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Wrap detect on the registered count, independent of capture activity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            cnt_q      <= cnt_in;
            wrap_pulse <= (cnt_q == '1) && (cnt_in == '0);
        end
    end

    sync_fifo #(
        .WIDTH (CNT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (cnt_in),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign out_valid = ~fifo_empty;

endmodule

// File: tb/tb_count_capture_unit.sv
// Bench for count_capture_unit: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_count_capture_unit;

    localparam int CNT_W   = 4;
    localparam int DEPTH   = 4;
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [CNT_W-1:0] cnt_in = '0;
    logic             evt_in = 1'b0;
    logic             out_ready = 1'b0;
    logic             clr_ovf = 1'b0;
    logic [CNT_W-1:0] out_data;
    logic             out_valid;
    logic [LVL_W-1:0] level;
    logic             full;
    logic             overflow;
    logic             wrap_pulse;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    count_capture_unit #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .evt_in     (evt_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .full       (full),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .wrap_pulse (wrap_pulse)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a capture is written at edge k when evt_in was sampled
    // high at edge k-3 and low at edge k-4; the stored value is cnt_in at edge k.
    int mq[$];
    bit m_ovf;
    bit m_wrap;
    bit hist[4];
    int m_cnt_prev;
    bit m_pop, m_push, m_drop;

    always @(posedge clk) begin
        if (!rst) begin
            mq.delete();
            m_ovf      = 1'b0;
            m_wrap     = 1'b0;
            hist       = '{default: 1'b0};
            m_cnt_prev = 0;
        end else begin
            m_pop  = (mq.size() > 0) && out_ready;
            m_push = hist[2] && !hist[3];
            m_drop = m_push && (mq.size() == DEPTH) && !m_pop;
            m_wrap = (m_cnt_prev == CNT_MAX) && (int'(cnt_in) == 0);
            m_cnt_prev = int'(cnt_in);
            if (m_pop) void'(mq.pop_front());
            if (m_push && !m_drop) mq.push_back(int'(cnt_in));
            if (m_drop) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            hist[3] = hist[2];
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = evt_in;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("out_valid", int'(out_valid), int'(mq.size() > 0));
            chk("level", int'(level), mq.size());
            chk("full", int'(full), int'(mq.size() == DEPTH));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("wrap_pulse", int'(wrap_pulse), int'(m_wrap));
            if (mq.size() > 0) chk("out_data", int'(out_data), mq[0]);
        end else begin
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_level", int'(level), 0);
            chk("rst_overflow", int'(overflow), 0);
            chk("rst_wrap", int'(wrap_pulse), 0);
        end
    end

    // Inputs change 1 time unit after the rising edge and hold until the next one.
    task automatic drive(input int c, input bit e, input bit r, input bit cl);
        cnt_in    = CNT_W'(c);
        evt_in    = e;
        out_ready = r;
        clr_ovf   = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        evt_in    = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        cnt_in    = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    int exp_t2[4] = '{3, 7, 11, 15};
    int exp_t3[4] = '{7, 11, 15, 3};
    int cnt_t4[8] = '{13, 14, 15, 15, 15, 0, 1, 2};
    int wrp_t4[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    int c;

    initial begin
        #1;
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_full", int'(full), 0);
        chk("reset_level", int'(level), 0);
        do_reset();

        // Single capture of value 7, then pop.
        for (int i = 0; i <= 7; i++) drive(i, i == 4, 1'b0, 1'b0);
        chk("t1_valid", int'(out_valid), 1);
        chk("t1_data", int'(out_data), 7);
        chk("t1_level", int'(level), 1);
        drive(8, 1'b0, 1'b1, 1'b0);
        chk("t1_pop_valid", int'(out_valid), 0);

        // Five events, no consumer: fifth dropped.
        do_reset();
        for (int i = 0; i <= 22; i++) drive(i, (i % 4 == 0) && (i <= 16), 1'b0, 1'b0);
        chk("t2_full", int'(full), 1);
        chk("t2_overflow", int'(overflow), 1);
        chk("t2_level", int'(level), 4);
        for (int k = 0; k < 4; k++) begin
            chk("t2_pop_data", int'(out_data), exp_t2[k]);
            drive(23 + k, 1'b0, 1'b1, 1'b0);
        end
        chk("t2_empty", int'(out_valid), 0);

        // Push and pop on the same edge while full.
        do_reset();
        for (int i = 0; i <= 18; i++) drive(i, (i % 4 == 0) && (i <= 16), 1'b0, 1'b0);
        chk("t3_level_pre", int'(level), 4);
        drive(19, 1'b0, 1'b1, 1'b0);
        chk("t3_level", int'(level), 4);
        chk("t3_overflow", int'(overflow), 0);
        for (int k = 0; k < 4; k++) begin
            chk("t3_pop_data", int'(out_data), exp_t3[k]);
            drive(20 + k, 1'b0, 1'b1, 1'b0);
        end

        // Wrap pulse only on 15 -> 0.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(cnt_t4[k], 1'b0, 1'b0, 1'b0);
            chk("t4_wrap", int'(wrap_pulse), wrp_t4[k]);
        end

        // Held event gives exactly one capture.
        do_reset();
        for (int i = 0; i < 20; i++) drive(i, 1'b1, 1'b0, 1'b0);
        chk("t5_held_level", int'(level), 1);

        // Clear coinciding with a drop keeps overflow set.
        do_reset();
        for (int i = 0; i <= 25; i++) begin
            drive(i, (i % 4 == 0) && (i <= 20), 1'b0, i == 23);
            if (i == 23) chk("t5_set_wins", int'(overflow), 1);
        end
        drive(26, 1'b0, 1'b0, 1'b1);
        chk("t5_clear", int'(overflow), 0);

        // Mid-operation reset with an event in flight.
        do_reset();
        for (int i = 0; i <= 12; i++) drive(i, (i % 4 == 0) && (i <= 12), 1'b0, 1'b0);
        chk("t6_level_pre", int'(level), 3);
        #2 rst = 1'b0;
        evt_in = 1'b0;
        #1;
        chk("t6_rst_level", int'(level), 0);
        chk("t6_rst_valid", int'(out_valid), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 8; i++) drive(i, 1'b0, 1'b0, 1'b0);
        chk("t6_no_capture", int'(level), 0);

        // Event already high at reset release gives one capture.
        rst    = 1'b0;
        evt_in = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 8; i++) drive(i, 1'b1, 1'b0, 1'b0);
        chk("t7_release_capture", int'(level), 1);

        // Random traffic against the model.
        do_reset();
        c = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) do_reset();
            if ($urandom_range(0, 9) == 0) c = int'($urandom_range(0, CNT_MAX));
            else if ($urandom_range(0, 5) != 0) c = c + 1;
            drive(c,
                  ($urandom_range(0, 2) == 0) ? ~evt_in : evt_in,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 15) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
